// File: rtl/display_scheduler_if.sv
// Bundle of value sources, alert channel and display outputs for display_scheduler.
interface display_scheduler_if;
  logic [17:0] src0_val;
  logic [17:0] src1_val;
  logic [17:0] src2_val;
  logic [2:0]  src_en;
  logic        alert_req;
  logic [17:0] alert_val;
  logic [17:0] disp_val;
  logic [1:0]  disp_sel;
  logic        disp_blank;
  logic        alert_busy;
  logic        page_tick;

  modport master (
    output src0_val, src1_val, src2_val, src_en, alert_req, alert_val,
    input  disp_val, disp_sel, disp_blank, alert_busy, page_tick
  );

  modport slave (
    input  src0_val, src1_val, src2_val, src_en, alert_req, alert_val,
    output disp_val, disp_sel, disp_blank, alert_busy, page_tick
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin display sharing of three sources with a pre-empting alert channel.
// Alert blink is built only when DISPLAY_SCHED_BLINK_EN is defined.
module display_scheduler #(
  parameter int unsigned DWELL      = 50_000_000,
  parameter int unsigned ALERT_HOLD = 150_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  display_scheduler_if.slave bus
);
  localparam int unsigned DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int unsigned HD_W = (ALERT_HOLD > 2) ? $clog2(ALERT_HOLD) : 1;

  if (DWELL < 2) begin : g_chk_dwell
    $error("DWELL must be at least 2");
  end
  if (ALERT_HOLD < 2) begin : g_chk_hold
    $error("ALERT_HOLD must be at least 2");
  end
  if (BLINK_HALF < 1) begin : g_chk_blink
    $error("BLINK_HALF must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_ALERT} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [DW_W-1:0] r_dwell, w_dwell_nxt;
  logic [HD_W-1:0] r_hold, w_hold_nxt;
  logic [17:0]     r_alert_val, w_alert_val_nxt;
  logic [17:0]     r_disp_val, w_disp_val_nxt;
  logic [1:0]      r_disp_sel, w_disp_sel_nxt;
  logic            r_disp_blank, w_disp_blank_nxt;
  logic            r_alert_busy, w_alert_busy_nxt;
  logic            r_page_tick, w_page_tick_nxt;
  logic [17:0]     w_src_sel;
  logic            w_alert_blank;

  // First enabled index scanning start, start+1, start+2 (mod 3); start if none.
  function automatic logic [1:0] scan_from(input logic [1:0] start, input logic [2:0] en);
    logic [1:0] idx;
    logic       found;
    scan_from = start;
    found     = 1'b0;
    idx       = start;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && en[idx]) begin
        scan_from = idx;
        found     = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    wrap_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef DISPLAY_SCHED_BLINK_EN
  localparam int unsigned BL_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  logic [BL_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic            r_blink, w_blink_nxt;

  // Any alert request restarts the blink phase at "visible".
  always_comb begin
    w_blink_cnt_nxt = '0;
    w_blink_nxt     = 1'b0;
    if (!bus.alert_req && r_state == S_ALERT) begin
      if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
        w_blink_nxt = ~r_blink;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BL_W'(1);
        w_blink_nxt     = r_blink;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink     <= w_blink_nxt;
    end
  end

  assign w_alert_blank = w_blink_nxt;
`else
  assign w_alert_blank = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_dwell_nxt     = r_dwell;
    w_hold_nxt      = r_hold;
    w_alert_val_nxt = r_alert_val;
    if (bus.alert_req) begin
      w_state_nxt     = S_ALERT;
      w_alert_val_nxt = bus.alert_val;
      w_hold_nxt      = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.src_en != '0) begin
            w_state_nxt = S_ROTATE;
            w_ptr_nxt   = scan_from(r_ptr, bus.src_en);
            w_dwell_nxt = '0;
          end
        end
        S_ROTATE: begin
          if (bus.src_en == '0) begin
            w_state_nxt = S_IDLE;
          end else if (!bus.src_en[r_ptr] || r_dwell == DW_W'(DWELL - 1)) begin
            w_ptr_nxt   = scan_from(wrap_inc(r_ptr), bus.src_en);
            w_dwell_nxt = '0;
          end else begin
            w_dwell_nxt = r_dwell + DW_W'(1);
          end
        end
        S_ALERT: begin
          if (r_hold == HD_W'(ALERT_HOLD - 1)) begin
            w_state_nxt = (bus.src_en == '0) ? S_IDLE : S_ROTATE;
            w_dwell_nxt = '0;
          end else begin
            w_hold_nxt = r_hold + HD_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so they track the state with no extra lag.
  always_comb begin
    case (w_ptr_nxt)
      2'd1:    w_src_sel = bus.src1_val;
      2'd2:    w_src_sel = bus.src2_val;
      default: w_src_sel = bus.src0_val;
    endcase
  end

  always_comb begin
    w_disp_val_nxt   = '0;
    w_disp_sel_nxt   = '0;
    w_disp_blank_nxt = 1'b1;
    w_alert_busy_nxt = 1'b0;
    w_page_tick_nxt  = (w_ptr_nxt != r_ptr);
    case (w_state_nxt)
      S_ROTATE: begin
        w_disp_val_nxt   = w_src_sel;
        w_disp_sel_nxt   = w_ptr_nxt;
        w_disp_blank_nxt = 1'b0;
      end
      S_ALERT: begin
        w_disp_val_nxt   = w_alert_val_nxt;
        w_disp_sel_nxt   = 2'd3;
        w_disp_blank_nxt = w_alert_blank;
        w_alert_busy_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_dwell      <= '0;
      r_hold       <= '0;
      r_alert_val  <= '0;
      r_disp_val   <= '0;
      r_disp_sel   <= '0;
      r_disp_blank <= 1'b1;
      r_alert_busy <= 1'b0;
      r_page_tick  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_dwell      <= w_dwell_nxt;
      r_hold       <= w_hold_nxt;
      r_alert_val  <= w_alert_val_nxt;
      r_disp_val   <= w_disp_val_nxt;
      r_disp_sel   <= w_disp_sel_nxt;
      r_disp_blank <= w_disp_blank_nxt;
      r_alert_busy <= w_alert_busy_nxt;
      r_page_tick  <= w_page_tick_nxt;
    end
  end

  assign bus.disp_val   = r_disp_val;
  assign bus.disp_sel   = r_disp_sel;
  assign bus.disp_blank = r_disp_blank;
  assign bus.alert_busy = r_alert_busy;
  assign bus.page_tick  = r_page_tick;
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the board's six-digit HEX display among three 18-bit value sources plus a priority alert channel. Upstream game logic presents its values (score, timer, level, …). This block sequences which one is shown, rotating round-robin with a fixed dwell time and pre-empting for alerts. Its `disp_val` output drives the `entrada` input of the existing display block; `disp_blank` gates the segment drivers.

## Interface

Parameters:
- `DWELL`, default 50_000_000: cycles each source stays on the display. Must be ≥ 2.
- `ALERT_HOLD`, default 150_000_000: cycles an alert stays on the display. Must be ≥ 2.
- `BLINK_HALF`, default 12_500_000: half-period of the alert blink, in cycles. Used only when blink is compiled in.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `src0_val`, `src1_val`, `src2_val` in 18 each: live source values.
- `src_en` in 3: per-source enable. Bit i set means source i takes part in rotation.
- `alert_req` in 1: single-cycle request to show `alert_val`.
- `alert_val` in 18: alert value, sampled in the cycle `alert_req` is high.
- `disp_val` out 18: value sent to the display.
- `disp_sel` out 2: what is shown. 0–2 is a source index; 3 is the alert.
- `disp_blank` out 1: 1 blanks all digits.
- `alert_busy` out 1: high while in ALERT.
- `page_tick` out 1: one-cycle pulse whenever the rotation pointer changes.

## Operation

- States are IDLE, ROTATE and ALERT. Internal state:
  - `ptr` (2 bits, values 0–2),
  - dwell counter,
  - hold counter,
  - captured alert value.
- Reset values:
  - state IDLE, `ptr` 0, all counters 0,
  - `disp_val` 0, `disp_sel` 0, `disp_blank` 1,
  - `alert_busy` 0, `page_tick` 0.
- next(p) is the first enabled index scanning p+1, p+2, p+3 (mod 3). If only p is enabled, next(p) = p.
- IDLE:
  - Output: `disp_blank` = 1, `disp_val` = 0.
  - If `src_en` ≠ 0: go to ROTATE. `ptr` becomes the first enabled index at or after the current `ptr`, and the dwell counter clears.
- ROTATE:
  - Output: `disp_val` = src[`ptr`], `disp_sel` = `ptr`, `disp_blank` = 0.
  - The dwell counter increments every cycle.
  - When the counter reaches DWELL−1: `ptr` becomes next(`ptr`) and the counter clears.
  - If `src_en[ptr]` drops while other sources are enabled: advance immediately and clear the counter.
  - If `src_en` = 0: go to IDLE.
- ALERT:
  - Output: `disp_val` = captured alert value, `disp_sel` = 3, `alert_busy` = 1.
  - The hold counter increments every cycle. At ALERT_HOLD−1, return to ROTATE, or to IDLE if `src_en` = 0.
  - On return, `ptr` is unchanged and the dwell counter restarts at 0.
  - The rotation pointer is frozen during ALERT. `src_en` changes take effect after exit.
- Alert entry and priority:
  - `alert_req` in any state captures `alert_val`, clears the hold counter and enters ALERT.
  - This includes ALERT itself: a repeat request retriggers the hold and replaces the value.
  - If `alert_req` coincides with dwell expiry, the alert wins and `ptr` does not advance.
  - If `alert_req` coincides with an `src_en` change, the alert wins.
- `page_tick` is high in the cycle after any `ptr` update where the new value ≠ the old value. The IDLE→ROTATE pointer load counts.
- Width rule: values pass through unmodified. 18 bits is at most 262143, which always fits 6 digits, so no clamping is needed.

## Timing

- All outputs are registered. `disp_val` follows the selected source with 1-cycle latency; the live value is resampled every cycle.
- Each source is displayed for exactly DWELL cycles between page changes.
- An alert appears on the outputs 1 cycle after `alert_req` is high. It is displayed for exactly ALERT_HOLD cycles after its last request.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). Operation resumes from IDLE on the first clock after release.

## Configuration

- `DISPLAY_SCHED_BLINK_EN` defined:
  - In ALERT, `disp_blank` starts at 0 and toggles every BLINK_HALF cycles. The blink counter clears on each alert (re)entry.
  - `disp_blank` returns to 0 on exit to ROTATE.
- `DISPLAY_SCHED_BLINK_EN` undefined:
  - `disp_blank` = 0 throughout ALERT.
  - No blink counter logic is built.

## Test plan

All scenarios use DWELL=4, ALERT_HOLD=6, BLINK_HALF=2.

- Reset, then `src_en`=000 -> `disp_blank`=1, `disp_val`=0, `disp_sel`=0 indefinitely.
- `src_en`=111 with sources 11, 22, 33 -> `disp_val` sequence 11×4, 22×4, 33×4, 11… One `page_tick` pulse per change.
- `src_en`=101 -> sources 0 and 2 alternate every 4 cycles. Clear bit 2 while on source 2 -> source 0 shown next cycle, `page_tick`=1.
- `alert_req` with `alert_val`=999 in the same cycle as dwell expiry on source 1 -> 999 with `disp_sel`=3 for 6 cycles, then source 1 again for a full 4 cycles.
- Second `alert_req` (val 555) 3 cycles into an alert -> `disp_val`=555 for 6 cycles after the retrigger.
- With `DISPLAY_SCHED_BLINK_EN`: during an alert, `disp_blank` reads 0,0,1,1,0,0. Assert reset mid-alert -> `alert_busy`=0 and `disp_blank`=1 immediately.
